fivesons_game_ctrl: RTL and testbench
=====================================

# fivesons_game_ctrl

Game-state controller for the 16x16 five-in-a-row game, directly upstream of the VGA renderer. Turns the five push buttons into cursor moves and stone placements, keeps the packed board image, alternates turns, and detects a win incrementally around each newly placed stone. Its outputs drive the renderer's `board`, `gaming_status`, `pointer_loc_x` and `pointer_loc_y` inputs unchanged.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable-low cycles that qualifies a press (10 ms at 50 MHz).

**Ports**
- `Clck` in, 1: the single clock (50 MHz).
- `Reset` in, 1: asynchronous, active-high reset.
- `btn_n` in, 5: active-low raw buttons, asynchronous to `Clck`. [0] up, [1] down, [2] left, [3] right, [4] place.
- `board` out, 512: packed cells. Cell (x,y) occupies bits [x*2 + y*32 +: 2]. Encoding: 00 empty, 01 black, 10 white; 11 is never written.
- `gaming_status` out, 2: 00 black to move, 01 white to move, 10 black won, 11 white won.
- `pointer_loc_x` out, 4: cursor column.
- `pointer_loc_y` out, 4: cursor row.

## Operation

**Input path (per button)**
- 2-flop synchronizer, then a debounce counter.
- The counter clears whenever the synced level is high.
- A press event is a one-cycle pulse emitted when the counter reaches `DEBOUNCE_CYCLES`.
- Only one event is emitted per press. Re-arming requires `DEBOUNCE_CYCLES` of stable high.

**Event priority (same cycle)**
- place > up > down > left > right.
- Losing events are discarded.

**FSM states**
- IDLE
  - Move events: y-1 / y+1 / x-1 / x+1, saturating at 0 and 15 (no wrap).
  - Place, target cell non-empty: ignored.
  - Place, target cell empty: write the stone colour (black if status 00, white if 01) at the cursor, latch its coordinates, go to CHECK.
- CHECK
  - Win checker walks 4 directions in order: horizontal, vertical, diagonal, anti-diagonal.
  - Each direction walks the positive side, then the negative side, one cell per cycle.
  - Each side stops at the board edge, at a non-matching cell, or after 5 steps.
  - count = 1 + pos + neg.
  - All button events are discarded in this state.
- DECIDE
  - Any direction qualifies as a win: status becomes 10 (black) or 11 (white), go to OVER.
  - Otherwise: toggle 00<->01, go to IDLE.
- OVER
  - All events are ignored. Only `Reset` leaves this state.

**Other rules**
- A full board with no win stays in IDLE. No draw state exists.
- The cursor never moves outside CHECK or OVER restrictions above, i.e. it is frozen in CHECK and OVER.

## Timing

**Reset values**
- `board`: 0.
- `gaming_status`: 00.
- `pointer_loc_x` = 7, `pointer_loc_y` = 7.
- FSM: IDLE.
- All sync, debounce and checker registers: cleared.

**Latencies**
- Press to action: button low at the pin produces the output update within `DEBOUNCE_CYCLES` + 4 cycles.
- Placement: the `board` update is visible the cycle after the place event is accepted.
- Verdict: `gaming_status` updates at most 42 cycles after the placement edge (4 directions x 10 steps + start + decide).

**Boundary conditions**
- `Reset` mid-CHECK aborts the check immediately; all state takes reset values.
- Outputs are registered and change only on `Clck` edges or on `Reset`.

## Configuration

Macro: `FIVESONS_EXACT_FIVE_EN`
- Defined: a direction wins only if count == 5. An overline (count >= 6) does not win and play continues.
- Undefined: any count >= 5 wins.
- The walk limit stays 5 per side in both builds, so overlines are always measured.

## Structure

- **Package `fivesons_pkg`**
  - Cell encodings: EMPTY, BLACK, WHITE.
  - Status encodings.
  - Board dimension constant: 16.
  - Cell-offset function: x*2 + y*32.
  - FSM state enum.
- **Sub-module `fivesons_win_checker`**
  - Inputs: board, origin (x,y), colour, start.
  - Outputs: done pulse, win flag.
  - Contains the direction/side/step counters and the exact-five logic.
- The button synchronizer and debouncer are instantiated 5 times as a generate loop inside the top.

## Test plan

Bench uses `DEBOUNCE_CYCLES` = 4.

1. **Reset and cursor moves.** Reset, then press up 9 times. Pointer (7,0): moves saturate at 0. Then press right 10 times: pointer (15,0).
2. **Placement and occupied cell.** Place at (7,7): `board`[238 +: 2] = 01, status 01. Place again at (7,7): board and status unchanged.
3. **Horizontal win.** Black at (3..7,5), white elsewhere off-line. After black's fifth stone: status 10 within 42 cycles; further presses change nothing.
4. **Diagonal win at edge.** White at (11..15,11..15). Status 11. Walks stop at the edge with no out-of-range access.
5. **Overline.** Black at (0..3,0) and (5,0), then place (4,0).
   - With `FIVESONS_EXACT_FIVE_EN` defined: status 01.
   - Without it: status 10.
6. **Reset during CHECK and simultaneous presses.**
   - Assert `Reset` 3 cycles into CHECK: board 0, status 00, pointer (7,7).
   - Press up and place together: only the placement occurs.

Source files
------------

// File: rtl/fivesons_pkg.sv
// fivesons_pkg: shared encodings, board geometry and FSM states for the five-in-a-row controller
package fivesons_pkg;

    localparam int         BOARD_DIM = 16;
    localparam logic [3:0] POS_MAX   = 4'(BOARD_DIM - 1);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    localparam logic [1:0] ST_BLACK_MOVE = 2'b00;
    localparam logic [1:0] ST_WHITE_MOVE = 2'b01;
    localparam logic [1:0] ST_BLACK_WON  = 2'b10;
    localparam logic [1:0] ST_WHITE_WON  = 2'b11;

    // Walk directions, checked in this order
    localparam logic [1:0] DIR_H = 2'd0;
    localparam logic [1:0] DIR_V = 2'd1;
    localparam logic [1:0] DIR_D = 2'd2;
    localparam logic [1:0] DIR_A = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DECIDE, S_OVER} state_e;

    // Bit offset of cell (x,y) in the packed board: x*2 + y*32
    function automatic logic [8:0] cell_off(input logic [3:0] x, input logic [3:0] y);
        return {y, x, 1'b0};
    endfunction

endpackage

// File: rtl/fivesons_win_checker.sv
// fivesons_win_checker: incremental win detection walking outward from the newest stone
//   clk, rst      : clock, asynchronous active-high reset
//   board         : packed board image (already holding the new stone)
//   org_x, org_y  : origin cell, latched on start
//   colour        : colour of the new stone, latched on start
//   start         : one-cycle request
//   done          : one-cycle pulse when all four directions are walked
//   win           : verdict, valid from done until the next start
// Macro FIVESONS_EXACT_FIVE_EN: only a run of exactly five wins.
module fivesons_win_checker
    import fivesons_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] board,
    input  logic [3:0]   org_x,
    input  logic [3:0]   org_y,
    input  logic [1:0]   colour,
    input  logic         start,
    output logic         done,
    output logic         win
);
    logic       busy_q, busy_d, neg_q, neg_d, win_q, win_d, done_q, done_d;
    logic [1:0] dir_q, dir_d, col_q, col_d;
    logic [2:0] step_q, step_d;
    logic [3:0] ox_q, ox_d, oy_q, oy_d, cx_q, cx_d, cy_q, cy_d, cnt_q, cnt_d;
    logic [3:0] nx, ny, cnt_sum;
    logic       mx, my, xinc, yinc, inb, hit, side_end, qual;

    // Probe of the next cell along the current direction and side
    always_comb begin
        mx       = dir_q != DIR_V;
        my       = dir_q != DIR_H;
        xinc     = !neg_q;
        yinc     = (dir_q == DIR_A) ? neg_q : !neg_q;
        nx       = !mx ? cx_q : xinc ? cx_q + 4'd1 : cx_q - 4'd1;
        ny       = !my ? cy_q : yinc ? cy_q + 4'd1 : cy_q - 4'd1;
        // Edge test is done on the current cell so a wrapped nx/ny is never trusted
        inb      = (!mx || cx_q != (xinc ? POS_MAX : 4'd0)) && (!my || cy_q != (yinc ? POS_MAX : 4'd0));
        hit      = busy_q && inb && board[cell_off(nx, ny) +: 2] == col_q;
        side_end = !hit || step_q == 3'd4;
        cnt_sum  = cnt_q + {3'd0, hit};
`ifdef FIVESONS_EXACT_FIVE_EN
        qual     = cnt_sum == 4'd5;
`else
        qual     = cnt_sum >= 4'd5;
`endif
    end

    always_comb begin
        busy_d = busy_q;
        neg_d  = neg_q;
        win_d  = win_q;
        done_d = 1'b0;
        dir_d  = dir_q;
        col_d  = col_q;
        step_d = step_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        cx_d   = cx_q;
        cy_d   = cy_q;
        cnt_d  = cnt_q;
        if (start) begin
            busy_d = 1'b1;
            neg_d  = 1'b0;
            win_d  = 1'b0;
            dir_d  = DIR_H;
            step_d = 3'd0;
            ox_d   = org_x;
            oy_d   = org_y;
            cx_d   = org_x;
            cy_d   = org_y;
            col_d  = colour;
            cnt_d  = 4'd1;
        end else if (busy_q) begin
            if (!side_end) begin
                cx_d   = nx;
                cy_d   = ny;
                step_d = step_q + 3'd1;
                cnt_d  = cnt_sum;
            end else begin
                cx_d   = ox_q;
                cy_d   = oy_q;
                step_d = 3'd0;
                neg_d  = !neg_q;
                cnt_d  = neg_q ? 4'd1 : cnt_sum;
                if (neg_q) begin
                    win_d  = win_q | qual;
                    dir_d  = dir_q + 2'd1;
                    busy_d = dir_q != DIR_A;
                    done_d = dir_q == DIR_A;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
            win_q  <= 1'b0;
            done_q <= 1'b0;
            dir_q  <= DIR_H;
            col_q  <= CELL_EMPTY;
            step_q <= 3'd0;
            ox_q   <= 4'd0;
            oy_q   <= 4'd0;
            cx_q   <= 4'd0;
            cy_q   <= 4'd0;
            cnt_q  <= 4'd0;
        end else begin
            busy_q <= busy_d;
            neg_q  <= neg_d;
            win_q  <= win_d;
            done_q <= done_d;
            dir_q  <= dir_d;
            col_q  <= col_d;
            step_q <= step_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            cx_q   <= cx_d;
            cy_q   <= cy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign done = done_q;
    assign win  = win_q;

endmodule

// File: rtl/fivesons_game_ctrl.sv
// fivesons_game_ctrl: buttons to cursor/placement, board image, turn order and win verdict
//   Clck          : 50 MHz clock
//   Reset         : asynchronous active-high reset
//   btn_n[4:0]    : active-low raw buttons {place, right, left, down, up}
//   board         : packed cells, (x,y) at [x*2 + y*32 +: 2]
//   gaming_status : 00 black/01 white to move, 10 black won, 11 white won
//   pointer_loc_x : cursor column
//   pointer_loc_y : cursor row
// Macro FIVESONS_EXACT_FIVE_EN (in the win checker): overlines do not win.
module fivesons_game_ctrl
    import fivesons_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         Clck,
    input  logic         Reset,
    input  logic [4:0]   btn_n,
    output logic [511:0] board,
    output logic [1:0]   gaming_status,
    output logic [3:0]   pointer_loc_x,
    output logic [3:0]   pointer_loc_y
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [4:0] sync1_q, sync2_q, ev;

    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Armed: count stable-low cycles, fire once and disarm.
    // Disarmed: count stable-high cycles, then re-arm.
    // Starting disarmed keeps the cleared synchronizer from looking like a press.
    for (genvar i = 0; i < 5; i++) begin : g_btn
        logic [CW-1:0] cnt_q, cnt_d;
        logic          armed_q, armed_d, low;
        assign low   = !sync2_q[i];
        assign ev[i] = armed_q && low && cnt_q == CNT_LAST;
        always_comb begin
            cnt_d   = (armed_q == low) ? cnt_q + 1'b1 : '0;
            armed_d = armed_q;
            if (armed_q == low && cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                armed_d = !armed_q;
            end
        end
        always_ff @(posedge Clck or posedge Reset) begin
            if (Reset) begin
                cnt_q   <= '0;
                armed_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                armed_q <= armed_d;
            end
        end
    end

    state_e       state_q, state_d;
    logic [511:0] board_q, board_d;
    logic [1:0]   status_q, status_d, stone;
    logic [3:0]   px_q, px_d, py_q, py_d;
    logic [8:0]   cur_off;
    logic         place_ok, chk_done, chk_win;

    assign cur_off  = cell_off(px_q, py_q);
    assign stone    = status_q[0] ? CELL_WHITE : CELL_BLACK;
    assign place_ok = state_q == S_IDLE && ev[4] && board_q[cur_off +: 2] == CELL_EMPTY;

    fivesons_win_checker u_chk (
        .clk    (Clck),
        .rst    (Reset),
        .board  (board_q),
        .org_x  (px_q),
        .org_y  (py_q),
        .colour (stone),
        .start  (place_ok),
        .done   (chk_done),
        .win    (chk_win)
    );

    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            board_q  <= '0;
            status_q <= ST_BLACK_MOVE;
            px_q     <= 4'd7;
            py_q     <= 4'd7;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            status_q <= status_d;
            px_q     <= px_d;
            py_q     <= py_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = place_ok ? S_CHECK : S_IDLE;
            S_CHECK:  state_d = chk_done ? S_DECIDE : S_CHECK;
            S_DECIDE: state_d = chk_win ? S_OVER : S_IDLE;
            default:  state_d = S_OVER;
        endcase
    end

    // A place event wins priority even when the cell is occupied, so the moves are dropped
    always_comb begin
        board_d  = board_q;
        status_d = status_q;
        px_d     = px_q;
        py_d     = py_q;
        if (place_ok)
            board_d[cur_off +: 2] = stone;
        if (state_q == S_DECIDE)
            status_d = chk_win ? {1'b1, status_q[0]} : {1'b0, ~status_q[0]};
        if (state_q == S_IDLE && !ev[4]) begin
            if (ev[0])
                py_d = (py_q == 4'd0) ? py_q : py_q - 4'd1;
            else if (ev[1])
                py_d = (py_q == POS_MAX) ? py_q : py_q + 4'd1;
            else if (ev[2])
                px_d = (px_q == 4'd0) ? px_q : px_q - 4'd1;
            else if (ev[3])
                px_d = (px_q == POS_MAX) ? px_q : px_q + 4'd1;
        end
    end

    assign board         = board_q;
    assign gaming_status = status_q;
    assign pointer_loc_x = px_q;
    assign pointer_loc_y = py_q;

endmodule

// File: tb/tb_fivesons_game_ctrl.sv
// tb_fivesons_game_ctrl: scoreboard bench driving button presses against a behavioural game model
module tb_fivesons_game_ctrl;

    localparam int         D    = 4;
    localparam logic [4:0] B_UP = 5'b00001;
    localparam logic [4:0] B_DN = 5'b00010;
    localparam logic [4:0] B_LT = 5'b00100;
    localparam logic [4:0] B_RT = 5'b01000;
    localparam logic [4:0] B_PL = 5'b10000;

    typedef struct packed {
        logic [511:0] brd;
        logic [1:0]   st;
        logic [3:0]   x;
        logic [3:0]   y;
    } exp_t;

    logic         Clck  = 1'b0;
    logic         Reset = 1'b1;
    logic [4:0]   btn_n = 5'h1f;
    logic [511:0] board;
    logic [1:0]   gaming_status;
    logic [3:0]   pointer_loc_x, pointer_loc_y;

    logic [1:0] m_board [16][16];
    logic [1:0] m_st;
    logic [3:0] m_px, m_py;
    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    fivesons_game_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .Clck          (Clck),
        .Reset         (Reset),
        .btn_n         (btn_n),
        .board         (board),
        .gaming_status (gaming_status),
        .pointer_loc_x (pointer_loc_x),
        .pointer_loc_y (pointer_loc_y)
    );

    always #5 Clck = ~Clck;

    task automatic model_reset();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                m_board[x][y] = 2'b00;
        m_st = 2'b00;
        m_px = 4'd7;
        m_py = 4'd7;
    endtask

    // Full line scan around (x,y): up to five cells each side, stopping at edges and foreign cells
    function automatic logic model_wins(input int x, input int y, input logic [1:0] c);
        int   dx[4] = '{1, 0, 1, 1};
        int   dy[4] = '{0, 1, 1, -1};
        int   n, xx, yy;
        logic run, w;
        w = 1'b0;
        for (int d = 0; d < 4; d++) begin
            n = 1;
            for (int s = -1; s <= 1; s += 2) begin
                run = 1'b1;
                for (int k = 1; k <= 5; k++) begin
                    xx = x + s * k * dx[d];
                    yy = y + s * k * dy[d];
                    if (run && xx >= 0 && xx < 16 && yy >= 0 && yy < 16)
                        run = m_board[xx][yy] == c;
                    else
                        run = 1'b0;
                    if (run) n++;
                end
            end
`ifdef FIVESONS_EXACT_FIVE_EN
            if (n == 5) w = 1'b1;
`else
            if (n >= 5) w = 1'b1;
`endif
        end
        return w;
    endfunction

    task automatic model_apply(input logic [4:0] m);
        logic [1:0] c;
        if (m_st[1]) return;
        if (m[4]) begin
            if (m_board[m_px][m_py] == 2'b00) begin
                c = m_st[0] ? 2'b10 : 2'b01;
                m_board[m_px][m_py] = c;
                m_st = model_wins(m_px, m_py, c) ? {1'b1, m_st[0]} : {1'b0, ~m_st[0]};
            end
        end else if (m[0]) begin
            if (m_py != 4'd0) m_py = m_py - 4'd1;
        end else if (m[1]) begin
            if (m_py != 4'd15) m_py = m_py + 4'd1;
        end else if (m[2]) begin
            if (m_px != 4'd0) m_px = m_px - 4'd1;
        end else if (m[3]) begin
            if (m_px != 4'd15) m_px = m_px + 4'd1;
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                e.brd[x*2 + y*32 +: 2] = m_board[x][y];
        e.st = m_st;
        e.x  = m_px;
        e.y  = m_py;
        return e;
    endfunction

    // One press: model result queued at drive time, popped once the allowed latency has elapsed
    task automatic press(input logic [4:0] mask);
        exp_t e, got;
        model_apply(mask);
        exp_q.push_back(snapshot());
        @(posedge Clck);
        #1 btn_n = ~mask;
        repeat (D + 4) @(posedge Clck);
        if (mask[4]) repeat (42) @(posedge Clck);
        #1;
        e   = exp_q.pop_front();
        got = {board, gaming_status, pointer_loc_x, pointer_loc_y};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL press_%b: board=%h status=%b ptr=(%0d,%0d) expected board=%h status=%b ptr=(%0d,%0d)",
                     mask, got.brd, got.st, got.x, got.y, e.brd, e.st, e.x, e.y);
        end
        btn_n = 5'h1f;
        repeat (D + 4) @(posedge Clck);
        #1;
    endtask

    task automatic goto_xy(input int x, input int y);
        while (m_py > y && !m_st[1]) press(B_UP);
        while (m_py < y && !m_st[1]) press(B_DN);
        while (m_px > x && !m_st[1]) press(B_LT);
        while (m_px < x && !m_st[1]) press(B_RT);
    endtask

    task automatic place_at(input int x, input int y);
        goto_xy(x, y);
        press(B_PL);
    endtask

    task automatic do_reset();
        btn_n = 5'h1f;
        @(posedge Clck);
        #1 Reset = 1'b1;
        repeat (2) @(posedge Clck);
        #1 Reset = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (D + 6) @(posedge Clck);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clck);
        #1;
        vectors++;
        if ({board, gaming_status, pointer_loc_x, pointer_loc_y} !== {512'd0, 2'b00, 4'd7, 4'd7}) begin
            miscompares++;
            $display("FAIL reset_held: status=%b ptr=(%0d,%0d) board_nonzero=%b, expected 00 (7,7) 0",
                     gaming_status, pointer_loc_x, pointer_loc_y, |board);
        end
        Reset = 1'b0;
        model_reset();
        repeat (D + 6) @(posedge Clck);
        #1;
        vectors++;
        if ({board, gaming_status, pointer_loc_x, pointer_loc_y} !== {512'd0, 2'b00, 4'd7, 4'd7}) begin
            miscompares++;
            $display("FAIL reset_release: status=%b ptr=(%0d,%0d), expected 00 (7,7)",
                     gaming_status, pointer_loc_x, pointer_loc_y);
        end
    endtask

    task automatic test_cursor();
        repeat (9) press(B_UP);
        vectors++;
        if ({pointer_loc_x, pointer_loc_y} !== {4'd7, 4'd0}) begin
            miscompares++;
            $display("FAIL top_saturate: ptr=(%0d,%0d), expected (7,0)", pointer_loc_x, pointer_loc_y);
        end
        repeat (10) press(B_RT);
        vectors++;
        if ({pointer_loc_x, pointer_loc_y} !== {4'd15, 4'd0}) begin
            miscompares++;
            $display("FAIL right_saturate: ptr=(%0d,%0d), expected (15,0)", pointer_loc_x, pointer_loc_y);
        end
    endtask

    task automatic test_place();
        place_at(7, 7);
        vectors++;
        if ({board[238 +: 2], gaming_status} !== {2'b01, 2'b01}) begin
            miscompares++;
            $display("FAIL first_stone: cell=%b status=%b, expected 01 01", board[238 +: 2], gaming_status);
        end
        press(B_PL);
    endtask

    task automatic test_horizontal_win();
        int sx[10] = '{0, 3, 2, 4, 4, 5, 6, 6, 8, 7};
        int sy[10] = '{12, 5, 12, 5, 12, 5, 12, 5, 12, 5};
        for (int i = 0; i < 10; i++) place_at(sx[i], sy[i]);
        vectors++;
        if (gaming_status !== 2'b10) begin
            miscompares++;
            $display("FAIL horizontal_win: status=%b, expected 10", gaming_status);
        end
        press(B_UP);
        press(B_PL);
        press(B_LT);
    endtask

    task automatic test_diag_edge();
        int sx[10] = '{0, 11, 2, 12, 4, 13, 6, 14, 0, 15};
        int sy[10] = '{0, 11, 0, 12, 0, 13, 0, 14, 2, 15};
        do_reset();
        for (int i = 0; i < 10; i++) place_at(sx[i], sy[i]);
        vectors++;
        if (gaming_status !== 2'b11) begin
            miscompares++;
            $display("FAIL diag_edge_win: status=%b, expected 11", gaming_status);
        end
    endtask

    task automatic test_overline();
        int         sx[11] = '{0, 0, 1, 2, 2, 4, 3, 6, 5, 8, 4};
        int         sy[11] = '{0, 15, 0, 15, 0, 15, 0, 15, 0, 15, 0};
        logic [1:0] want;
`ifdef FIVESONS_EXACT_FIVE_EN
        want = 2'b01;
`else
        want = 2'b10;
`endif
        do_reset();
        for (int i = 0; i < 11; i++) place_at(sx[i], sy[i]);
        vectors++;
        if (gaming_status !== want) begin
            miscompares++;
            $display("FAIL overline: status=%b, expected %b", gaming_status, want);
        end
    endtask

    task automatic test_reset_mid_check();
        int waited = 0;
        do_reset();
        @(posedge Clck);
        #1 btn_n = ~B_PL;
        while (board === 512'd0 && waited < D + 8) begin
            @(posedge Clck);
            #1;
            waited++;
        end
        vectors++;
        if (board === 512'd0) begin
            miscompares++;
            $display("FAIL placement_timeout: board still empty after %0d cycles, expected a stone", waited);
        end
        repeat (3) @(posedge Clck);
        #1 Reset = 1'b1;
        #1;
        vectors++;
        if ({board, gaming_status, pointer_loc_x, pointer_loc_y} !== {512'd0, 2'b00, 4'd7, 4'd7}) begin
            miscompares++;
            $display("FAIL reset_mid_check: status=%b ptr=(%0d,%0d) board_nonzero=%b, expected 00 (7,7) 0",
                     gaming_status, pointer_loc_x, pointer_loc_y, |board);
        end
        btn_n = 5'h1f;
        @(posedge Clck);
        #1 Reset = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (D + 6) @(posedge Clck);
        #1;
        press(B_UP | B_PL);
        vectors++;
        if ({board[238 +: 2], pointer_loc_x, pointer_loc_y} !== {2'b01, 4'd7, 4'd7}) begin
            miscompares++;
            $display("FAIL up_and_place: cell=%b ptr=(%0d,%0d), expected 01 (7,7)",
                     board[238 +: 2], pointer_loc_x, pointer_loc_y);
        end
    endtask

    initial begin
        test_reset();
        test_cursor();
        test_place();
        test_horizontal_win();
        test_diag_edge();
        test_overline();
        test_reset_mid_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
